// File: rtl/flash_pkg.sv
// flash_pkg: opcodes, FSM state type and SPI phase lengths shared by the
// spi_flash_reader slice.
package flash_pkg;

   localparam logic [7:0] FLASH_OP_READ      = 8'h03;
   localparam logic [7:0] FLASH_OP_FAST_READ = 8'h0B;

   localparam int CMD_BITS   = 8;
   localparam int ADDR_BITS  = 24;
   localparam int DUMMY_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_DATA,
      ST_HOLD
   } flash_state_t;

   function automatic logic [7:0] read_opcode(input logic fast);
      return fast ? FLASH_OP_FAST_READ : FLASH_OP_READ;
   endfunction

endpackage

// File: rtl/spi_flash_reader_if.sv
// spi_flash_reader_if: loader request/stream signals plus the flash bridge pins.
// The slave modport is the reader; the master modport is the loader/bridge side.
interface spi_flash_reader_if;
   import flash_pkg::*;

   logic         req;
   logic [23:0]  addr;
   logic [15:0]  len;
   logic         busy;
   logic         done;
   // Byte stream: a byte moves on every cycle with rd_valid && rd_ready. Once
   // raised, rd_valid and rd_data stay put until that handshake happens.
   logic [7:0]   rd_data;
   logic         rd_valid;
   logic         rd_ready;
   logic         dclk;
   logic         sce;
   logic         sdo;
   logic         data0;
   flash_state_t state;

   modport slave (
      input  req, addr, len, rd_ready, data0,
      output busy, done, rd_data, rd_valid, dclk, sce, sdo, state
   );

   modport master (
      output req, addr, len, rd_ready, data0,
      input  busy, done, rd_data, rd_valid, dclk, sce, sdo, state
   );

endinterface

// File: rtl/spi_bit_clk.sv
// spi_bit_clk: SCK generator toggling every CLK_DIV cycles while enabled.
// rise/fall strobe in the cycle before sck changes; stall freezes the clock.
module spi_bit_clk #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic stall,
   output logic sck,
   output logic rise,
   output logic fall
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          tick;

   assign tick = en && !stall && (cnt == LAST);
   assign rise = tick && !sck;
   assign fall = tick && sck;

   always_ff @(posedge clk) begin
      if (reset || !en) begin
         cnt <= '0;
         sck <= 1'b0;
      end else if (!stall) begin
         if (cnt == LAST) begin
            cnt <= '0;
            sck <= ~sck;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: SPI mode-0 flash read initiator streaming bytes out over rd_valid/rd_ready.
// Define FLASH_FAST_READ_EN for opcode 0x0B with an 8-clock dummy phase.
module spi_flash_reader
   import flash_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input logic               clk,
   input logic               reset,
   spi_flash_reader_if.slave bus
);

`ifdef FLASH_FAST_READ_EN
   localparam logic [7:0] OPCODE = read_opcode(1'b1);
`else
   localparam logic [7:0] OPCODE = read_opcode(1'b0);
`endif
   localparam int HW = $clog2(2 * CLK_DIV);

   flash_state_t  state;
   logic [30:0]   tx_q;
   logic [7:0]    rx_q;
   logic [4:0]    bit_cnt;
   logic [15:0]   rem;
   logic [HW-1:0] hold_cnt;
   logic          sce_q, sdo_q, busy_q, done_q, rd_valid_q;
   logic [7:0]    rd_data_q;
   logic          sck_en, stall, sck, rise, fall;

   assign sck_en = state inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA};
   // Park SCK low before the rise that would finish a byte nobody has taken yet.
   assign stall  = (state == ST_DATA) && (bit_cnt == 5'd7) && !sck &&
                   rd_valid_q && !bus.rd_ready;

   spi_bit_clk #(.CLK_DIV(CLK_DIV)) u_bit_clk (
      .clk   (clk),
      .reset (reset),
      .en    (sck_en),
      .stall (stall),
      .sck   (sck),
      .rise  (rise),
      .fall  (fall)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         tx_q       <= '0;
         rx_q       <= '0;
         bit_cnt    <= '0;
         rem        <= '0;
         hold_cnt   <= '0;
         sce_q      <= 1'b1;
         sdo_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         done_q <= 1'b0;
         if (rd_valid_q && bus.rd_ready) rd_valid_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.req) begin
                  if (bus.len == 16'd0) begin
                     done_q <= 1'b1;
                  end else begin
                     state   <= ST_CMD;
                     busy_q  <= 1'b1;
                     sce_q   <= 1'b0;
                     sdo_q   <= OPCODE[7];
                     tx_q    <= {OPCODE[6:0], bus.addr};
                     rem     <= bus.len;
                     bit_cnt <= '0;
                  end
               end
            end
            ST_CMD: begin
               if (fall) begin
                  sdo_q <= tx_q[30];
                  tx_q  <= {tx_q[29:0], 1'b0};
                  if (bit_cnt == 5'(CMD_BITS - 1)) begin
                     state   <= ST_ADDR;
                     bit_cnt <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
            end
            ST_ADDR: begin
               if (fall) begin
                  if (bit_cnt == 5'(ADDR_BITS - 1)) begin
                     sdo_q   <= 1'b0;
                     bit_cnt <= '0;
`ifdef FLASH_FAST_READ_EN
                     state   <= ST_DUMMY;
`else
                     state   <= ST_DATA;
`endif
                  end else begin
                     sdo_q   <= tx_q[30];
                     tx_q    <= {tx_q[29:0], 1'b0};
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
            end
`ifdef FLASH_FAST_READ_EN
            ST_DUMMY: begin
               if (fall) begin
                  if (bit_cnt == 5'(DUMMY_BITS - 1)) begin
                     state   <= ST_DATA;
                     bit_cnt <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
            end
`endif
            ST_DATA: begin
               if (rise) begin
                  rx_q    <= {rx_q[6:0], bus.data0};
                  bit_cnt <= bit_cnt + 5'd1;
               end else if (fall && bit_cnt == 5'd8) begin
                  // Byte is handed over on the fall so SCK is already low for HOLD.
                  rd_data_q  <= rx_q;
                  rd_valid_q <= 1'b1;
                  rem        <= rem - 16'd1;
                  bit_cnt    <= '0;
                  if (rem == 16'd1) begin
                     state    <= ST_HOLD;
                     sce_q    <= 1'b1;
                     hold_cnt <= '0;
                  end
               end
            end
            ST_HOLD: begin
               hold_cnt <= hold_cnt + HW'(1);
               if (hold_cnt == HW'(2 * CLK_DIV - 2)) done_q <= 1'b1;
               if (hold_cnt == HW'(2 * CLK_DIV - 1)) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.dclk     = sck;
   assign bus.sce      = sce_q;
   assign bus.sdo      = sdo_q;
   assign bus.state    = state;

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: directed + randomized bench with a behavioural SPI flash
// model and a byte scoreboard for spi_flash_reader (CLK_DIV=2).
module tb_spi_flash_reader;
   import flash_pkg::*;

   localparam int CLK_DIV = 2;
`ifdef FLASH_FAST_READ_EN
   localparam int         DUMMY = 8;
   localparam logic [7:0] OP    = 8'h0B;
`else
   localparam int         DUMMY = 0;
   localparam logic [7:0] OP    = 8'h03;
`endif
   localparam int LAT = 1 + (32 + DUMMY + 8) * 2 * CLK_DIV - 8 * 2 * CLK_DIV + 8 * 2 * CLK_DIV;

   logic clk;
   logic reset;
   spi_flash_reader_if bus();

   spi_flash_reader #(.CLK_DIV(CLK_DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mem [256];
   logic       sdo_bits[$];
   int         flash_rises = 0;
   logic [23:0] fl_addr = '0;
   logic       dclk_prev = 1'b0;
   int         done_cnt = 0;
   int         sce_low_cnt = 0;
   int         rdy_mode = 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- flash device model ----------------
   // Collects command/address bits on SCK rises, returns memory bits on falls.
   always @(negedge clk) begin
      if (bus.sce === 1'b1) begin
         flash_rises = 0;
         bus.data0   = 1'b0;
      end else if (bus.dclk === 1'b1 && dclk_prev === 1'b0) begin
         if (flash_rises < 32 + DUMMY) sdo_bits.push_back(bus.sdo);
         flash_rises++;
         if (flash_rises == 32) begin
            fl_addr = '0;
            for (int j = 8; j < 32; j++) fl_addr = {fl_addr[22:0], sdo_bits[j]};
         end
      end else if (bus.dclk === 1'b0 && dclk_prev === 1'b1 && flash_rises >= 32 + DUMMY) begin
         int k;
         logic [23:0] ba;
         k  = flash_rises - (32 + DUMMY);
         ba = fl_addr + 24'(k / 8);
         bus.data0 = mem[ba[7:0]][7 - (k % 8)];
      end
      dclk_prev = bus.dclk;
   end

   // ---------------- monitors / scoreboard ----------------
   always @(negedge clk) begin
      if (bus.done === 1'b1) done_cnt++;
      if (bus.sce === 1'b0) sce_low_cnt++;
   end

   always @(negedge clk) begin
      if (reset === 1'b0 && bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL extra_byte: observed %0h expected none", bus.rd_data);
         end else begin
            check("rd_data", {24'h0, bus.rd_data}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   // ---------------- consumer ready driver ----------------
   initial begin
      bus.rd_ready = 1'b1;
      forever begin
         tick();
         case (rdy_mode)
            0:       bus.rd_ready = 1'b0;
            1:       bus.rd_ready = 1'b1;
            default: bus.rd_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_xfer(input logic [23:0] a, input logic [15:0] l);
      for (int i = 0; i < int'(l); i++) begin
         logic [23:0] t;
         t = a + 24'(i);
         exp_q.push_back(mem[t[7:0]]);
      end
      sdo_bits.delete();
      bus.addr = a;
      bus.len  = l;
      bus.req  = 1'b1;
      tick();
      bus.req  = 1'b0;
   endtask

   function automatic logic [31:0] cmd_word();
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < 32; i++) w = {w[30:0], (i < sdo_bits.size()) ? sdo_bits[i] : 1'bx};
      return w;
   endfunction

   task automatic finish_xfer(input string tag, input int dc0, input logic [23:0] a);
      int n;
      n = 0;
      while (done_cnt == dc0 && n < 6000) begin
         tick();
         n++;
      end
      repeat (2) tick();
      check({tag, "_done_once"}, done_cnt - dc0, 1);
      check({tag, "_sce_high"}, {31'h0, bus.sce}, 1);
      check({tag, "_busy_low"}, {31'h0, bus.busy}, 0);
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         tick();
         n++;
      end
      check({tag, "_all_bytes"}, exp_q.size(), 0);
      check({tag, "_cmd_addr"}, cmd_word(), {OP, a});
`ifdef FLASH_FAST_READ_EN
      for (int i = 32; i < 40; i++) check({tag, "_dummy_sdo"}, {31'h0, sdo_bits[i]}, 0);
`endif
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int dc0, sl0, lat, n, hi;
      logic [23:0] a;
      bus.req  = 1'b0;
      bus.addr = '0;
      bus.len  = '0;
      reset    = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[8'h45] = 8'hA5;
      mem[8'h46] = 8'h5A;
      mem[8'h47] = 8'hFF;
      mem[8'h48] = 8'h00;

      repeat (3) tick();
      check("rst_sce", {31'h0, bus.sce}, 1);
      check("rst_dclk", {31'h0, bus.dclk}, 0);
      check("rst_sdo", {31'h0, bus.sdo}, 0);
      check("rst_busy", {31'h0, bus.busy}, 0);
      check("rst_done", {31'h0, bus.done}, 0);
      check("rst_rd_valid", {31'h0, bus.rd_valid}, 0);
      check("rst_rd_data", {24'h0, bus.rd_data}, 0);
      reset = 1'b0;
      tick();

      // Directed read of four known bytes plus first-byte latency.
      dc0 = done_cnt;
      start_xfer(24'h012345, 16'd4);
      check("t1_busy", {31'h0, bus.busy}, 1);
      check("t1_sce_low", {31'h0, bus.sce}, 0);
      check("t1_dclk_idle", {31'h0, bus.dclk}, 0);
      lat = 1;
      while (bus.rd_valid !== 1'b1 && lat < 1000) begin
         tick();
         lat++;
      end
      check("t1_latency_in_window", {31'h0, (lat >= LAT - 1 && lat <= LAT + 1)}, 1);
      finish_xfer("t1", dc0, 24'h012345);

      // Zero-length request.
      dc0 = done_cnt;
      sl0 = sce_low_cnt;
      start_xfer(24'($urandom), 16'd0);
      check("len0_done", {31'h0, bus.done}, 1);
      check("len0_sce", {31'h0, bus.sce}, 1);
      check("len0_busy", {31'h0, bus.busy}, 0);
      tick();
      check("len0_done_pulse", {31'h0, bus.done}, 0);
      repeat (3) tick();
      check("len0_done_cnt", done_cnt - dc0, 1);
      check("len0_sce_never_low", sce_low_cnt - sl0, 0);

      // Backpressure: consumer not ready for 100 cycles after first byte.
      rdy_mode = 0;
      tick();
      dc0 = done_cnt;
      a = 24'($urandom);
      start_xfer(a, 16'd3);
      n = 0;
      while (bus.rd_valid !== 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      check("stall_first_valid", {31'h0, bus.rd_valid}, 1);
      hi = 0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (c >= 40 && bus.dclk !== 1'b0) hi++;
      end
      check("stall_dclk_frozen", hi, 0);
      check("stall_valid_held", {31'h0, bus.rd_valid}, 1);
      check("stall_data_held", {24'h0, bus.rd_data}, {24'h0, exp_q[0]});
      check("stall_sce_low", {31'h0, bus.sce}, 0);
      rdy_mode = 1;
      finish_xfer("stall", dc0, a);

      // Reset in the middle of the address phase.
      dc0 = done_cnt;
      start_xfer(24'($urandom), 16'd2);
      n = 0;
      while (flash_rises < 12 && n < 500) begin
         tick();
         n++;
      end
      check("mid_state_addr", 32'(bus.state), 32'(ST_ADDR));
      reset = 1'b1;
      tick();
      check("mid_rst_sce", {31'h0, bus.sce}, 1);
      check("mid_rst_dclk", {31'h0, bus.dclk}, 0);
      check("mid_rst_sdo", {31'h0, bus.sdo}, 0);
      check("mid_rst_busy", {31'h0, bus.busy}, 0);
      check("mid_rst_valid", {31'h0, bus.rd_valid}, 0);
      check("mid_rst_state", 32'(bus.state), 32'(ST_IDLE));
      reset = 1'b0;
      exp_q.delete();
      repeat (20) tick();
      check("mid_rst_no_done", done_cnt - dc0, 0);
      dc0 = done_cnt;
      start_xfer(24'h000010, 16'd1);
      finish_xfer("after_rst", dc0, 24'h000010);

      // Address wrap at the top of the flash.
      dc0 = done_cnt;
      start_xfer(24'hFFFFFF, 16'd2);
      finish_xfer("wrap", dc0, 24'hFFFFFF);

      // Request while busy must be ignored.
      dc0 = done_cnt;
      a = 24'($urandom);
      start_xfer(a, 16'd3);
      repeat (20) tick();
      bus.addr = ~a;
      bus.len  = 16'd5;
      bus.req  = 1'b1;
      tick();
      bus.req  = 1'b0;
      finish_xfer("busy_req", dc0, a);
      sl0 = sce_low_cnt;
      repeat (200) tick();
      check("busy_req_no_second", sce_low_cnt - sl0, 0);
      check("busy_req_one_done", done_cnt - dc0, 1);

      // Randomized transfers with random consumer backpressure.
      rdy_mode = 2;
      for (int t = 0; t < 4; t++) begin
         dc0 = done_cnt;
         a = 24'($urandom);
         start_xfer(a, 16'($urandom_range(1, 5)));
         finish_xfer("rand", dc0, a);
      end
      rdy_mode = 1;
      repeat (5) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
